// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the 5-stage core's pipeline control.
//   state_t   - sequencing FSM states (IDLE, RUN, MEM_WAIT, FAULT)
//   REG_W     - register-specifier width
//   NOP_INSTR - encoding loaded by the IF/ID flush and ID/EX bubble consumers
package pipe_pkg;

    localparam int unsigned REG_W = 5;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        FAULT    = 2'd3
    } state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard/sequencing signals between the pipeline and hazard_ctrl.
//   slave  - hazard_ctrl side: samples stage status, drives control + counters
//   master - pipeline side: drives stage status, samples control + counters
interface hazard_ctrl_if
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) ();

    logic             start_i;
    logic             idex_memread_i;
    logic [REG_W-1:0] idex_rt_i;
    logic [REG_W-1:0] ifid_rs_i;
    logic [REG_W-1:0] ifid_rt_i;
    logic             ifid_uses_rt_i;
    logic             branch_taken_i;
    logic             mem_req_i;
    logic             mem_ack_i;

    logic             run_o;
    logic             pc_stall_o;
    logic             ifid_stall_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             pipe_freeze_o;
    logic             fault_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic [CNT_W-1:0] wait_cnt_o;

    modport slave (
        input  start_i, idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
               ifid_uses_rt_i, branch_taken_i, mem_req_i, mem_ack_i,
        output run_o, pc_stall_o, ifid_stall_o, ifid_flush_o, idex_bubble_o,
               pipe_freeze_o, fault_o, stall_cnt_o, flush_cnt_o, wait_cnt_o
    );

    modport master (
        output start_i, idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
               ifid_uses_rt_i, branch_taken_i, mem_req_i, mem_ack_i,
        input  run_o, pc_stall_o, ifid_stall_o, ifid_flush_o, idex_bubble_o,
               pipe_freeze_o, fault_o, stall_cnt_o, flush_cnt_o, wait_cnt_o
    );

endinterface

// File: rtl/hazard_ctrl_load_use_detect.sv
// load_use_detect: combinational load-use register compare.
//   idex_memread_i - EX holds a load
//   idex_rt_i      - load destination register
//   ifid_rs_i/rt_i - ID source registers
//   ifid_uses_rt_i - ID instruction actually reads rt
//   hazard_o       - ID must wait one cycle for the load data
module load_use_detect
    import pipe_pkg::*;
(
    input  logic             idex_memread_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    input  logic             ifid_uses_rt_i,
    output logic             hazard_o
);

    always_comb begin
        hazard_o = 1'b0;
        // $zero is never a real dependency
        if (idex_memread_i && (idex_rt_i != '0)) begin
            hazard_o = (idex_rt_i == ifid_rs_i) ||
                       (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i));
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage core.
//   clk_i, rst_i (async, active-low)
//   bus (hazard_ctrl_if.slave):
//     in : start_i, load-use operands, branch_taken_i, mem_req_i/mem_ack_i
//     out: run_o/pc_stall_o (PC start/stall), IF/ID stall/flush, ID/EX bubble,
//          pipe_freeze_o, sticky fault_o, saturating stall/flush/wait counters
// Control outputs are combinational from state and inputs; state, wait timer
// and counters are registered.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    hazard_ctrl_if.slave bus
);

    localparam int unsigned         TMR_W   = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0]    TMR_MAX = TMR_W'(TIMEOUT);

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] wait_cnt;

    logic hazard;
    logic mem_wait;
    logic run_c, pc_stall_c, ifid_stall_c, ifid_flush_c;
    logic idex_bubble_c, pipe_freeze_c, fault_c;

    load_use_detect u_lud (
        .idex_memread_i (bus.idex_memread_i),
        .idex_rt_i      (bus.idex_rt_i),
        .ifid_rs_i      (bus.ifid_rs_i),
        .ifid_rt_i      (bus.ifid_rt_i),
        .ifid_uses_rt_i (bus.ifid_uses_rt_i),
        .hazard_o       (hazard)
    );

    assign mem_wait = bus.mem_req_i && !bus.mem_ack_i;

    // Defaults are the held/idle pattern; only RUN without a memory wait
    // lets the pipe move.
    always_comb begin
        run_c         = 1'b0;
        pc_stall_c    = 1'b1;
        ifid_stall_c  = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_bubble_c = 1'b0;
        pipe_freeze_c = 1'b1;
        fault_c       = 1'b0;
        unique case (state)
            IDLE: ;
            RUN: begin
                run_c = 1'b1;
                if (!mem_wait) begin
                    pc_stall_c    = hazard;
                    ifid_stall_c  = hazard;
                    idex_bubble_c = hazard;
                    pipe_freeze_c = 1'b0;
                    // a stalled branch is seen again next cycle
                    ifid_flush_c  = bus.branch_taken_i && !hazard;
                end
            end
            MEM_WAIT: run_c = 1'b1;
            FAULT:    fault_c = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            timer     <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            if (idex_bubble_c && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (ifid_flush_c && (flush_cnt != '1))  flush_cnt <= flush_cnt + 1'b1;
            if ((state == MEM_WAIT) && (wait_cnt != '1)) wait_cnt <= wait_cnt + 1'b1;

            unique case (state)
                IDLE: begin
                    if (bus.start_i) state <= RUN;
                end
                RUN: begin
                    if (mem_wait) begin
                        state <= MEM_WAIT;
                        timer <= TMR_W'(1);
                    end else if (!bus.start_i) begin
                        state <= IDLE;
                    end
                end
                MEM_WAIT: begin
                    // a start_i drop during the wait is honoured only at the ack
                    if (bus.mem_ack_i) begin
                        state <= bus.start_i ? RUN : IDLE;
                        timer <= '0;
                    end else if (timer == TMR_MAX) begin
                        state <= FAULT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                FAULT: ;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.run_o         = run_c;
    assign bus.pc_stall_o    = pc_stall_c;
    assign bus.ifid_stall_o  = ifid_stall_c;
    assign bus.ifid_flush_o  = ifid_flush_c;
    assign bus.idex_bubble_o = idex_bubble_c;
    assign bus.pipe_freeze_o = pipe_freeze_c;
    assign bus.fault_o       = fault_c;
    assign bus.stall_cnt_o   = stall_cnt;
    assign bus.flush_cnt_o   = flush_cnt;
    assign bus.wait_cnt_o    = wait_cnt;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage core. It decides each cycle whether the program counter, the IF/ID register and the ID/EX register advance, hold, flush or take a bubble. It drives the PC's `start_i`/`stall_i` pair, freezes the whole pipe during data-memory waits, and keeps stall/flush performance counters. It sits beside the PC and pipeline registers and takes inputs from the ID stage, the EX stage and the data-memory port.

## Interface
- `TIMEOUT`, default 256: maximum memory-wait cycles before a fault is flagged.
- `CNT_W`, default 32: width of the performance counters.

- `clk_i  in  1`: clock.
- `rst_i  in  1`: reset, asynchronous, active-low.
- `start_i  in  1`: core enable from the testbench/top level.
- `idex_memread_i  in  1`: instruction in EX is a load.
- `idex_rt_i  in  5`: load destination register.
- `ifid_rs_i  in  5`: ID source register rs.
- `ifid_rt_i  in  5`: ID source register rt.
- `ifid_uses_rt_i  in  1`: ID instruction reads rt.
- `branch_taken_i  in  1`: branch resolved taken in ID.
- `mem_req_i  in  1`: MEM stage access in progress.
- `mem_ack_i  in  1`: memory access completes this cycle.
- `run_o  out  1`: drives PC `start_i`.
- `pc_stall_o  out  1`: drives PC `stall_i`.
- `ifid_stall_o  out  1`: IF/ID hold.
- `ifid_flush_o  out  1`: IF/ID clear to NOP.
- `idex_bubble_o  out  1`: ID/EX load NOP.
- `pipe_freeze_o  out  1`: all stages from EX onward hold.
- `fault_o  out  1`: sticky memory timeout.
- `stall_cnt_o  out  CNT_W`: load-use stall cycles.
- `flush_cnt_o  out  CNT_W`: flush cycles.
- `wait_cnt_o  out  CNT_W`: memory-wait cycles.

## Operation
- FSM states: IDLE, RUN, MEM_WAIT, FAULT.
- IDLE: `run_o`=0; all stall/freeze outputs are 1; flush and bubble are 0. The FSM goes to RUN on `start_i`=1.
- RUN: `run_o`=1.
  - Load-use hazard is `idex_memread_i` && `idex_rt_i`≠0 && (`idex_rt_i`==`ifid_rs_i` || (`ifid_uses_rt_i` && `idex_rt_i`==`ifid_rt_i`)). On a hazard, `pc_stall_o`, `ifid_stall_o` and `idex_bubble_o` are 1, and `stall_cnt_o` increments.
  - `branch_taken_i` with no hazard sets `ifid_flush_o`=1 and increments `flush_cnt_o`. The PC is not stalled, so it loads the target. A hazard suppresses the flush; the branch is re-evaluated the following cycle.
  - `mem_req_i`=1 with `mem_ack_i`=0 asserts every stall plus `pipe_freeze_o` combinationally, suppresses bubble and flush, and moves the FSM to MEM_WAIT. With `mem_req_i`=1 and `mem_ack_i`=1 there is no stall.
  - `start_i`=0 moves the FSM to IDLE, unless a memory wait is pending, in which case MEM_WAIT takes priority.
- MEM_WAIT: all stalls and `pipe_freeze_o` are 1, and `wait_cnt_o` increments. The wait counter starts at 1 on entry.
  - `mem_ack_i`=1: the outputs still show the freeze this cycle, and the FSM moves to RUN next cycle.
  - The counter reaching `TIMEOUT` without an ack moves the FSM to FAULT.
- FAULT: `fault_o`=1, `run_o`=0, all stalls 1. Only reset exits this state.
- Priority: FAULT/IDLE > memory wait > load-use > branch flush.
- All three performance counters saturate at all-ones.

## Timing
- Control outputs are combinational from the state and current inputs, so they take effect at the next edge.
- A load-use hazard costs exactly 1 stall cycle.
- A taken branch costs 1 flushed slot.
- A memory access with ack in cycle N after the request in cycle 0 costs N frozen cycles.
- Reset values:
  - state IDLE, `run_o`=0;
  - `pc_stall_o`, `ifid_stall_o` and `pipe_freeze_o` = 1;
  - `ifid_flush_o`, `idex_bubble_o` and `fault_o` = 0;
  - all counters and the wait timer = 0.
- Asserting reset mid-operation returns everything to the reset values immediately (asynchronous), including clearing FAULT.
- `start_i` deasserting during MEM_WAIT is ignored until the ack; the FSM then goes to IDLE instead of RUN.

## Structure
- Shared package `pipe_pkg` holds:
  - the state enum (IDLE, RUN, MEM_WAIT, FAULT);
  - `REG_W`=5;
  - the NOP encoding used by the flush and bubble consumers.
- Sub-module `load_use_detect` holds the combinational register compare, so the forwarding unit can reuse it.
- The counters are inline.

## Test plan
- Reset, then `start_i`=1 at cycle 3 → `run_o` rises at cycle 4 and `pc_stall_o` drops; a PC driven with `pc_i`=PC+4 reaches 0x4 after the first RUN edge.
- `idex_memread_i`=1, `idex_rt_i`=8, `ifid_rs_i`=8 for one cycle → exactly one cycle of `pc_stall_o`, `ifid_stall_o` and `idex_bubble_o` = 1; `stall_cnt_o`=1. With `idex_rt_i`=0 → no stall.
- Hazard and `branch_taken_i` in the same cycle → no flush that cycle; the next cycle with the branch held and no hazard gives `ifid_flush_o`=1 and `flush_cnt_o`=1.
- `mem_req_i` in cycle 0 and ack in cycle 3 → freeze in cycles 0–3, RUN in cycle 4, `wait_cnt_o`=3.
- `TIMEOUT`=8 with the ack never arriving → `fault_o`=1 after 8 wait cycles and stays set; asserting `rst_i` clears it.
- Reset asserted during MEM_WAIT → all outputs at reset values within the same cycle; counters read 0.
